io_switch_in_port: RTL and testbench
====================================

Name: io_switch_in_port

Overview:
- Input-side counterpart of the seven-segment output path. It captures the ten asynchronous slide switches, then synchronizes and debounces them.
- It packs the debounced values into the two 32-bit input-port words that the CPU reads.
- It provides a sticky "changed" flag and a CPU read-acknowledge handshake, so software can poll for new operands without rereading stale data.
- It sits between the board switch pins and the in_port0/in_port1 inputs of the CPU core.

Parameters:
- N_SW, 10, number of switch inputs. Fixed at 10 for the packing rules below.
- DEB_CYCLES, 500000, number of consecutive cycles a synchronized bit must differ from its stable value before the stable value is updated. 500000 is 10 ms at 50 MHz. Legal range is 2 or more.
- CNT_W, 20, width of each per-bit debounce counter. Must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk, in, 1: system clock. All logic is on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- sw, in, 10: raw asynchronous switch levels. sw[0] is SW0.
- rd_ack, in, 1: one-cycle pulse from the CPU bus when either input port is read. Clears changed.
- in_port0, out, 32: {27'b0, stable[9:5]}. SW5 is the LSB.
- in_port1, out, 32: {27'b0, stable[4:0]}. SW0 is the LSB.
- changed, out, 1: sticky flag, set when any debounced bit changes value.
- sw_stable, out, 10: debounced switch vector, exported for LEDs and debug.

Behaviour:
- Synchronizer:
  - Two flip-flop stages per bit: s1 <= sw, then s2 <= s1.
  - No logic between the two stages.
- Debounce, per bit i, evaluated every cycle:
  - If s2[i] == stable[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEB_CYCLES-1: stable[i] <= s2[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - A glitch shorter than DEB_CYCLES synchronized cycles never reaches stable. Any return to the old level restarts the count from 0.
- Latency:
  - sw is changed before edge 1 and held.
  - s2 reflects the change after edge 2.
  - stable updates at edge DEB_CYCLES+2.
  - in_port0/in_port1 and changed reflect it at edge DEB_CYCLES+3, because the output registers are separate from stable.
- Output registers:
  - in_port0, in_port1 and sw_stable are registered copies of stable, updated every cycle.
  - Upper 27 bits are always 0.
- Changed handshake:
  - upd = OR over i of the per-bit update events, sampled the cycle after the stable update so that it aligns with the in_port update.
  - If upd: changed <= 1.
  - Else if rd_ack: changed <= 0.
  - Else: changed holds.
  - Set has priority over clear when both occur in the same cycle. The CPU then sees changed=1 on its next poll.
  - rd_ack while changed=0 has no effect.
- Multiple bits:
  - Each bit debounces independently.
  - Bits that update in different cycles each produce an upd event. changed stays 1 until a later rd_ack with no coincident update.
- Reset (synchronous, has priority over all other logic):
  - s1, s2, stable, all cnt, in_port0, in_port1, sw_stable and changed are set to 0.
  - Switches that are high during reset appear only after the full latency measured from the first cycle after reset is deasserted. That appearance sets changed.
  - Reset asserted mid-count discards the partial count.
- There is no wrap-around condition: cnt never exceeds DEB_CYCLES-1.

Test Plan:
- Reset and idle:
  - Stimulus: DEB_CYCLES=4, sw=0, reset for 3 cycles, then run 20 cycles.
  - Required response: in_port0=in_port1=0, changed=0 throughout.
- Clean press with exact latency:
  - Stimulus: DEB_CYCLES=4; after reset, set sw=10'b00000_00101 before edge 1 and hold.
  - Required response: in_port1 becomes 32'h00000005 exactly at edge 7, not at edge 6. changed=1 at edge 7. in_port0 stays 0.
- Glitch rejection:
  - Stimulus: DEB_CYCLES=4; pulse sw[7] high for 3 cycles, then return it low.
  - Required response: in_port0 stays 0 and changed stays 0 for 20 cycles.
  - Repeat with a 6-cycle pulse: in_port0 becomes 32'h00000004 and changed=1.
- Read-acknowledge handshake:
  - Stimulus: with changed=1, pulse rd_ack for 1 cycle.
  - Required response: changed=0 on the next edge.
  - Then arrange for an upd event to coincide with an rd_ack pulse: changed stays 1.
- Upper-byte packing:
  - Stimulus: sw=10'h3FF held.
  - Required response: in_port0=in_port1=32'h0000001F, sw_stable=10'h3FF.
- Reset mid-operation:
  - Stimulus: DEB_CYCLES=4; toggle sw[0], then assert reset at edge 4 for 1 cycle while sw[0] is still held high.
  - Required response: outputs are 0 during reset. in_port1=1 appears 7 edges after reset is deasserted.

Source files
------------

// File: rtl/io_switch_in_port.sv
// Slide-switch input port: two-stage synchronizer, per-bit debounce, packing into
// the two CPU input-port words, and a sticky "changed" flag cleared by CPU reads.
module io_switch_in_port #(
  parameter int N_SW       = 10,
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw,
  input  logic            rd_ack,
  output logic [31:0]     in_port0,
  output logic [31:0]     in_port1,
  output logic            changed,
  output logic [N_SW-1:0] sw_stable
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [N_SW-1:0]  r_s1;
  logic [N_SW-1:0]  r_s2;
  logic [N_SW-1:0]  r_stable;
  logic [CNT_W-1:0] r_cnt [N_SW];
  logic [N_SW-1:0]  w_upd_evt;
  logic             r_upd;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two synchronizer stages.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= sw;
      r_s2 <= r_s1;
    end
  end

  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    w_upd_evt = '0;
    for (int i = 0; i < N_SW; i++) begin
      w_upd_evt[i] = (r_s2[i] != r_stable[i]) && (r_cnt[i] == LP_CNT_LAST);
    end
  end

  // Each bit counts consecutive disagreeing cycles independently; any agreement restarts it.
  // NOTE: the counter array is small flop storage, not RAM, so it is reset explicitly.
  for (genvar g = 0; g < N_SW; g++) begin : g_deb
    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt[g]    <= '0;
        r_stable[g] <= 1'b0;
      end else if (r_s2[g] == r_stable[g]) begin
        r_cnt[g] <= '0;
      end else if (w_upd_evt[g]) begin
        r_stable[g] <= r_s2[g];
        r_cnt[g]    <= '0;
      end else begin
        r_cnt[g] <= r_cnt[g] + 1'b1;
      end
    end
  end

  // Update event is delayed one cycle so changed rises with the new in_port words.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_upd     <= 1'b0;
      changed   <= 1'b0;
      in_port0  <= '0;
      in_port1  <= '0;
      sw_stable <= '0;
    end else begin
      r_upd     <= |w_upd_evt;
      in_port0  <= {27'b0, r_stable[9:5]};
      in_port1  <= {27'b0, r_stable[4:0]};
      sw_stable <= r_stable;
      if (r_upd) begin
        changed <= 1'b1;
      end else if (rd_ack) begin
        changed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_io_switch_in_port.sv
// Directed bench for io_switch_in_port with DEB_CYCLES=4; inputs change 1 ns after
// a rising edge and outputs are sampled at the same point.
module tb_io_switch_in_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  sw;
  logic        rd_ack;
  logic [31:0] in_port0;
  logic [31:0] in_port1;
  logic        changed;
  logic [9:0]  sw_stable;

  int n_tests = 0;
  int n_fail  = 0;

  io_switch_in_port #(
    .N_SW       (10),
    .DEB_CYCLES (4),
    .CNT_W      (3)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .rd_ack    (rd_ack),
    .in_port0  (in_port0),
    .in_port1  (in_port1),
    .changed   (changed),
    .sw_stable (sw_stable)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ack();
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    sw     = '0;
    rd_ack = 1'b0;

    // Reset and idle
    tick(3);
    check("rst_p0", in_port0, 32'h0);
    check("rst_p1", in_port1, 32'h0);
    check("rst_chg", {31'b0, changed}, 32'h0);
    check("rst_stab", {22'b0, sw_stable}, 32'h0);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      check("idle_p0", in_port0, 32'h0);
      check("idle_p1", in_port1, 32'h0);
      check("idle_chg", {31'b0, changed}, 32'h0);
    end

    // Clean press: visible at edge 7, not edge 6
    sw = 10'b00000_00101;
    tick(6);
    check("press_e6_p1", in_port1, 32'h0);
    check("press_e6_chg", {31'b0, changed}, 32'h0);
    tick(1);
    check("press_e7_p1", in_port1, 32'h5);
    check("press_e7_p0", in_port0, 32'h0);
    check("press_e7_chg", {31'b0, changed}, 32'h1);
    check("press_e7_stab", {22'b0, sw_stable}, 32'h005);

    // Read acknowledge clears changed
    pulse_ack();
    check("ack_clr", {31'b0, changed}, 32'h0);
    pulse_ack();
    check("ack_idle", {31'b0, changed}, 32'h0);

    // 3-cycle glitch on sw[7] is rejected
    sw = 10'h085;
    tick(3);
    sw = 10'h005;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      check("glitch_p0", in_port0, 32'h0);
      check("glitch_chg", {31'b0, changed}, 32'h0);
    end

    // 6-cycle pulse on sw[7] passes, then its release also passes
    sw = 10'h085;
    tick(6);
    sw = 10'h005;
    tick(1);
    check("pulse6_p0", in_port0, 32'h4);
    check("pulse6_chg", {31'b0, changed}, 32'h1);
    check("pulse6_p1", in_port1, 32'h5);
    tick(5);
    check("rel_e12_p0", in_port0, 32'h4);
    tick(1);
    check("rel_e13_p0", in_port0, 32'h0);
    check("rel_e13_chg", {31'b0, changed}, 32'h1);
    pulse_ack();
    check("ack2_clr", {31'b0, changed}, 32'h0);

    // Update coinciding with rd_ack: set wins
    sw = 10'h007;
    tick(6);
    check("coin_pre_chg", {31'b0, changed}, 32'h0);
    pulse_ack();
    check("coin_chg", {31'b0, changed}, 32'h1);
    check("coin_p1", in_port1, 32'h7);
    pulse_ack();
    check("coin_clr", {31'b0, changed}, 32'h0);

    // All switches high: both words carry 5 ones
    sw = 10'h3FF;
    tick(7);
    check("all_p0", in_port0, 32'h1F);
    check("all_p1", in_port1, 32'h1F);
    check("all_stab", {22'b0, sw_stable}, 32'h3FF);
    check("all_chg", {31'b0, changed}, 32'h1);

    // Reset mid-count discards progress; full latency from deassertion
    sw    = '0;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mid_pre_p0", in_port0, 32'h0);
    sw = 10'h001;
    tick(3);
    reset = 1'b1;
    tick(1);
    check("mid_rst_p1", in_port1, 32'h0);
    check("mid_rst_p0", in_port0, 32'h0);
    check("mid_rst_chg", {31'b0, changed}, 32'h0);
    reset = 1'b0;
    tick(6);
    check("mid_e6_p1", in_port1, 32'h0);
    tick(1);
    check("mid_e7_p1", in_port1, 32'h1);
    check("mid_e7_chg", {31'b0, changed}, 32'h1);
    check("mid_e7_stab", {22'b0, sw_stable}, 32'h001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
